key_conditioner: RTL and testbench

Front-end input stage of the combination lock: takes the raw push-button and slide-switch pins from the board and delivers clean, clock-synchronous signals to the lock FSM. Each key is synchronised, debounced and turned into a one-cycle press pulse; these pulses are the lock's `enter` and `change` strobes. The switch bank is synchronised and debounced as a vector. The lock's combo comparison uses only the debounced switch value, never the raw pins.

---
 rtl/lock_pkg.sv | 20 ++
 rtl/debounce_chan.sv | 79 +++++++
 rtl/key_conditioner.sv | 84 ++++++++
 tb/tb_key_conditioner.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Constants shared by the combination lock front end and the lock FSM.
package lock_pkg;

  // Push-button channels and their roles in the key vector.
  localparam int LOCK_N_KEYS = 2;
  localparam int KEY_ENTER   = 0;
  localparam int KEY_CHANGE  = 1;

  // Combination switch bank width.
  localparam int LOCK_SW_WIDTH = 4;

  // Default number of consecutive stable cycles before a change is accepted.
  localparam int LOCK_DEBOUNCE_CYCLES = 50000;

  // Width of a counter that must be able to hold the value `cycles`.
  function automatic int count_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// Synchroniser, stable-cycle counter and debounced output register for a
// group of WIDTH pins that are accepted together through one shared counter.
// With WIDTH=1 this behaves as a per-key debouncer: the counter runs while
// the synchronised sample differs from the debounced level.
module debounce_chan
  import lock_pkg::*;
#(
  parameter int               WIDTH           = 1,
  parameter int               DEBOUNCE_CYCLES = LOCK_DEBOUNCE_CYCLES,
  parameter logic [WIDTH-1:0] INVERT          = '0
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] sample,
  output logic [WIDTH-1:0] level,
  output logic             accept
);

  localparam int            CW   = count_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_reg;
  logic [WIDTH-1:0] sync2_reg;
  logic [WIDTH-1:0] prev_reg;
  logic [WIDTH-1:0] level_reg;
  logic [WIDTH-1:0] level_next;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    count_next;
  logic [CW-1:0]    run;

  // Polarity-corrected synchronised value; 1 means "pressed" for keys.
  assign sample = sync2_reg ^ INVERT;
  assign level  = level_reg;

  // Two-flop synchroniser; reset loads the released pin state so a pin held
  // through reset is seen as a fresh edge once reset is released.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sync1_reg <= INVERT;
      sync2_reg <= INVERT;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Count consecutive cycles of an unchanged sample that differs from the
  // debounced level; the cycle that reaches DEBOUNCE_CYCLES loads it. The
  // count never passes LAST because reaching it always triggers a load.
  always_comb begin
    run        = (sample == prev_reg) ? count_reg : '0;
    count_next = '0;
    level_next = level_reg;
    accept     = 1'b0;
    if (sample != level_reg) begin
      if (run == LAST) begin
        accept     = 1'b1;
        level_next = sample;
      end else begin
        count_next = run + CW'(1);
      end
    end
  end

  // Counter, previous-sample and debounced level registers.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      prev_reg  <= '0;
      count_reg <= '0;
      level_reg <= '0;
    end else begin
      prev_reg  <= sample;
      count_reg <= count_next;
      level_reg <= level_next;
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Lock input front end: debounced key levels with one-cycle press strobes,
// and a debounced switch bank with a registered "settled" flag.
module key_conditioner
  import lock_pkg::*;
#(
  parameter int N_KEYS          = LOCK_N_KEYS,
  parameter int SW_WIDTH        = LOCK_SW_WIDTH,
  parameter int DEBOUNCE_CYCLES = LOCK_DEBOUNCE_CYCLES,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic [N_KEYS-1:0]   key_raw,
  input  logic [SW_WIDTH-1:0] sw_raw,
  output logic [N_KEYS-1:0]   key_level,
  output logic [N_KEYS-1:0]   key_pulse,
  output logic [SW_WIDTH-1:0] sw_out,
  output logic                sw_stable
);

  localparam logic KEY_INVERT = KEY_ACTIVE_LOW;

  logic [N_KEYS-1:0]   key_sample;
  logic [N_KEYS-1:0]   key_accept;
  logic [N_KEYS-1:0]   key_pulse_reg;
  logic [SW_WIDTH-1:0] sw_sample;
  logic                sw_accept;
  logic                sw_stable_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      debounce_chan #(
        .WIDTH          (1),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .INVERT         (KEY_INVERT)
      ) u_key (
        .Clock (Clock),
        .Resetn(Resetn),
        .raw   (key_raw[gi]),
        .sample(key_sample[gi]),
        .level (key_level[gi]),
        .accept(key_accept[gi])
      );
    end
  endgenerate

  debounce_chan #(
    .WIDTH          (SW_WIDTH),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .INVERT         ({SW_WIDTH{1'b0}})
  ) u_sw (
    .Clock (Clock),
    .Resetn(Resetn),
    .raw   (sw_raw),
    .sample(sw_sample),
    .level (sw_out),
    .accept(sw_accept)
  );

  // A key load always flips the level, so a load of a pressed sample is a
  // press; the strobe lands on the same edge the level first reads 1.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      key_pulse_reg <= '0;
    end else begin
      key_pulse_reg <= key_accept & key_sample;
    end
  end

  // Settled flag compares against the switch value held before this edge;
  // on a load edge the new value is not yet in sw_out, so it reads 0.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      sw_stable_reg <= 1'b0;
    end else begin
      sw_stable_reg <= sw_accept ? 1'b0 : (sw_sample == sw_out);
    end
  end

  assign key_pulse = key_pulse_reg;
  assign sw_stable = sw_stable_reg;

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner with DEBOUNCE_CYCLES=4, active-low keys.
// Reference model: raw pins reach the debouncer two edges late; an output
// takes value x once its last D pre-edge samples were all x and x differs
// from the current output.
module tb_key_conditioner;

  localparam int D = 4;

  logic       Clock   = 1'b0;
  logic       Resetn  = 1'b0;
  logic [1:0] key_raw = 2'b11;
  logic [3:0] sw_raw  = 4'b0000;
  logic [1:0] key_level;
  logic [1:0] key_pulse;
  logic [3:0] sw_out;
  logic       sw_stable;

  int vectors     = 0;
  int miscompares = 0;

  key_conditioner #(
    .N_KEYS         (2),
    .SW_WIDTH       (4),
    .DEBOUNCE_CYCLES(D),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .Clock    (Clock),
    .Resetn   (Resetn),
    .key_raw  (key_raw),
    .sw_raw   (sw_raw),
    .key_level(key_level),
    .key_pulse(key_pulse),
    .sw_out   (sw_out),
    .sw_stable(sw_stable)
  );

  always #5 Clock = ~Clock;

  // Reference model state
  logic [1:0] m_level;
  logic [1:0] m_pulse;
  logic [3:0] m_sw_out;
  logic       m_stable;
  logic [1:0] kq[$];
  logic [3:0] sq[$];
  logic [1:0] kwin[$];
  logic [3:0] swin[$];

  function automatic void model_reset();
    m_level  = 2'b00;
    m_pulse  = 2'b00;
    m_sw_out = 4'b0000;
    m_stable = 1'b0;
    kq.delete();
    sq.delete();
    kq.push_back(2'b11);
    kq.push_back(2'b11);
    sq.push_back(4'b0000);
    sq.push_back(4'b0000);
    kwin.delete();
    swin.delete();
  endfunction

  function automatic void model_edge(input logic rstn, input logic [1:0] kraw, input logic [3:0] sraw);
    logic [1:0] s;
    logic [3:0] v;
    logic [1:0] new_level;
    logic       all_same;
    if (!rstn) begin
      model_reset();
      return;
    end
    s = kq.pop_front() ^ 2'b11;
    kq.push_back(kraw);
    v = sq.pop_front();
    sq.push_back(sraw);
    kwin.push_back(s);
    if (kwin.size() > D) void'(kwin.pop_front());
    swin.push_back(v);
    if (swin.size() > D) void'(swin.pop_front());
    new_level = m_level;
    for (int i = 0; i < 2; i++) begin
      all_same = (kwin.size() == D);
      foreach (kwin[j]) if (kwin[j][i] != s[i]) all_same = 1'b0;
      if (all_same && s[i] != m_level[i]) new_level[i] = s[i];
    end
    m_pulse  = new_level & ~m_level;
    m_level  = new_level;
    m_stable = (v == m_sw_out);
    all_same = (swin.size() == D);
    foreach (swin[j]) if (swin[j] != v) all_same = 1'b0;
    if (all_same && v != m_sw_out) m_sw_out = v;
  endfunction

  task automatic tick();
    @(posedge Clock);
    model_edge(Resetn, key_raw, sw_raw);
    #1;
  endtask

  task automatic test_reset();
    Resetn  = 1'b0;
    key_raw = 2'b11;
    sw_raw  = 4'b1010;
    for (int e = 0; e < 2; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== 11'b0) begin
        miscompares++;
        $display("FAIL reset_outputs: lvl=%b pls=%b sw=%b st=%b expected all 0", key_level, key_pulse, sw_out, sw_stable);
      end
    end
    Resetn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL reset_model e%0d: lvl=%b pls=%b sw=%b st=%b expected lvl=%b pls=%b sw=%b st=%b", e, key_level, key_pulse, sw_out, sw_stable, m_level, m_pulse, m_sw_out, m_stable);
      end
      if (e == 4) begin
        vectors++;
        if (sw_out !== 4'b0000) begin
          miscompares++;
          $display("FAIL reset_sw_early: sw_out=%b expected 0000", sw_out);
        end
      end
      if (e == 5) begin
        vectors++;
        if (sw_out !== 4'b1010 || sw_stable !== 1'b0) begin
          miscompares++;
          $display("FAIL reset_sw_load: sw_out=%b st=%b expected 1010 st=0", sw_out, sw_stable);
        end
      end
      if (e == 6) begin
        vectors++;
        if (sw_stable !== 1'b1) begin
          miscompares++;
          $display("FAIL reset_sw_stable: sw_stable=%b expected 1", sw_stable);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    key_raw[0] = 1'b0;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL press_model e%0d: lvl=%b pls=%b sw=%b st=%b expected lvl=%b pls=%b sw=%b st=%b", e, key_level, key_pulse, sw_out, sw_stable, m_level, m_pulse, m_sw_out, m_stable);
      end
      if (e == 4 || e == 5 || e == 6) begin
        vectors++;
        if ({key_level[0], key_pulse[0]} !== ((e == 4) ? 2'b00 : (e == 5) ? 2'b11 : 2'b10)) begin
          miscompares++;
          $display("FAIL press_timing e%0d: lvl0=%b pls0=%b", e, key_level[0], key_pulse[0]);
        end
      end
    end
    key_raw[0] = 1'b1;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL release_model e%0d: lvl=%b pls=%b expected lvl=%b pls=%b", e, key_level, key_pulse, m_level, m_pulse);
      end
      vectors++;
      if (key_pulse[0] !== 1'b0) begin
        miscompares++;
        $display("FAIL release_pulse e%0d: pls0=%b expected 0", e, key_pulse[0]);
      end
      if (e == 4 || e == 5) begin
        vectors++;
        if (key_level[0] !== (e == 4)) begin
          miscompares++;
          $display("FAIL release_level e%0d: lvl0=%b expected %b", e, key_level[0], e == 4);
        end
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int c = 0; c < 20; c++) begin
      key_raw[1] = ((c / 2) % 2 == 1);
      tick();
      if (key_pulse[1] === 1'b1) pulses++;
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL bounce_model c%0d: lvl=%b pls=%b expected lvl=%b pls=%b", c, key_level, key_pulse, m_level, m_pulse);
      end
    end
    key_raw[1] = 1'b0;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (key_pulse[1] === 1'b1) pulses++;
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL bounce_settle_model e%0d: lvl=%b pls=%b expected lvl=%b pls=%b", e, key_level, key_pulse, m_level, m_pulse);
      end
      if (e == 5) begin
        vectors++;
        if (key_pulse[1] !== 1'b1) begin
          miscompares++;
          $display("FAIL bounce_pulse_time: pls1=%b expected 1", key_pulse[1]);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
    end
    key_raw[1] = 1'b1;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_simultaneous();
    key_raw = 2'b00;
    for (int e = 0; e < 10; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL simul_model e%0d: lvl=%b pls=%b expected lvl=%b pls=%b", e, key_level, key_pulse, m_level, m_pulse);
      end
      if (e >= 4 && e <= 6) begin
        vectors++;
        if (key_pulse !== ((e == 5) ? 2'b11 : 2'b00)) begin
          miscompares++;
          $display("FAIL simul_pulse e%0d: pls=%b expected %b", e, key_pulse, (e == 5) ? 2'b11 : 2'b00);
        end
      end
    end
    key_raw = 2'b11;
    for (int e = 0; e < 8; e++) begin
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL simul_release_model e%0d: lvl=%b pls=%b expected lvl=%b pls=%b", e, key_level, key_pulse, m_level, m_pulse);
      end
    end
  endtask

  task automatic test_switch_glitch();
    logic saw_drop = 1'b0;
    sw_raw = 4'b0110;
    for (int e = 0; e < 8; e++) tick();
    vectors++;
    if (sw_out !== 4'b0110 || sw_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_setup: sw_out=%b st=%b expected 0110 st=1", sw_out, sw_stable);
    end
    for (int c = 0; c < 13; c++) begin
      sw_raw = (c < 3) ? 4'b0111 : 4'b0110;
      tick();
      if (sw_stable === 1'b0) saw_drop = 1'b1;
      vectors++;
      if (sw_out !== 4'b0110) begin
        miscompares++;
        $display("FAIL glitch_hold c%0d: sw_out=%b expected 0110", c, sw_out);
      end
      vectors++;
      if ({sw_out, sw_stable} !== {m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL glitch_model c%0d: sw=%b st=%b expected sw=%b st=%b", c, sw_out, sw_stable, m_sw_out, m_stable);
      end
    end
    vectors++;
    if (saw_drop !== 1'b1 || sw_stable !== 1'b1) begin
      miscompares++;
      $display("FAIL glitch_stable: dropped=%b final=%b expected dropped=1 final=1", saw_drop, sw_stable);
    end
  endtask

  task automatic test_midcount_reset();
    int pulses = 0;
    key_raw = 2'b10;
    for (int e = 0; e < 3; e++) begin
      tick();
      vectors++;
      if (key_pulse !== 2'b00) begin
        miscompares++;
        $display("FAIL midreset_early e%0d: pls=%b expected 00", e, key_pulse);
      end
    end
    Resetn = 1'b0;
    tick();
    vectors++;
    if ({key_level, key_pulse, sw_out, sw_stable} !== 11'b0) begin
      miscompares++;
      $display("FAIL midreset_reset: lvl=%b pls=%b sw=%b st=%b expected all 0", key_level, key_pulse, sw_out, sw_stable);
    end
    Resetn = 1'b1;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (key_pulse[0] === 1'b1) pulses++;
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL midreset_model e%0d: lvl=%b pls=%b sw=%b st=%b expected lvl=%b pls=%b sw=%b st=%b", e, key_level, key_pulse, sw_out, sw_stable, m_level, m_pulse, m_sw_out, m_stable);
      end
      if (e == 5) begin
        vectors++;
        if (key_pulse[0] !== 1'b1) begin
          miscompares++;
          $display("FAIL midreset_pulse_time: pls0=%b expected 1", key_pulse[0]);
        end
      end
    end
    vectors++;
    if (pulses != 1) begin
      miscompares++;
      $display("FAIL midreset_pulse_count: got %0d expected 1", pulses);
    end
    key_raw = 2'b11;
    for (int e = 0; e < 8; e++) tick();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 600; c++) begin
      if (hold == 0) begin
        key_raw = 2'($urandom_range(0, 3));
        sw_raw  = 4'($urandom_range(0, 15));
        hold    = $urandom_range(1, 9);
      end
      hold--;
      Resetn = ($urandom_range(0, 79) != 0);
      tick();
      vectors++;
      if ({key_level, key_pulse, sw_out, sw_stable} !== {m_level, m_pulse, m_sw_out, m_stable}) begin
        miscompares++;
        $display("FAIL random_model c%0d: lvl=%b pls=%b sw=%b st=%b expected lvl=%b pls=%b sw=%b st=%b", c, key_level, key_pulse, sw_out, sw_stable, m_level, m_pulse, m_sw_out, m_stable);
      end
    end
    Resetn = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_switch_glitch();
    test_midcount_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
